// File: rtl/gpu_issue_scheduler_if.sv
// ---------------------------------------------------------------------------
// gpu_issue_scheduler_if
// Bundles every signal of the issue scheduler except clk/rst.
//   decode side : in_valid/in_ready, in_opcode, in_rd, in_rs1..in_rs3, flush
//   issue bus   : iss_opcode, iss_rd, iss_rs1..iss_rs3 (shared by all units)
//   units       : alu/div/fpu valid+ready pairs, fpu_long
//   writeback   : wb_valid[2:0] (ALU, DIV, FPU), wb_rd (3 packed lanes)
//   status      : illegal_valid, illegal_opcode, stall_cnt
// modport master : the scheduler itself
// modport slave  : the surrounding pipeline (decode, units, writeback)
// ---------------------------------------------------------------------------
interface gpu_issue_scheduler_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_opcode;
  logic [REG_W-1:0]     in_rd;
  logic [REG_W-1:0]     in_rs1;
  logic [REG_W-1:0]     in_rs2;
  logic [REG_W-1:0]     in_rs3;
  logic                 flush;

  logic [7:0]           iss_opcode;
  logic [REG_W-1:0]     iss_rd;
  logic [REG_W-1:0]     iss_rs1;
  logic [REG_W-1:0]     iss_rs2;
  logic [REG_W-1:0]     iss_rs3;

  logic                 alu_valid;
  logic                 alu_ready;
  logic                 div_valid;
  logic                 div_ready;
  logic                 fpu_valid;
  logic                 fpu_ready;
  logic                 fpu_long;

  logic [2:0]           wb_valid;
  logic [3*REG_W-1:0]   wb_rd;

  logic                 illegal_valid;
  logic [7:0]           illegal_opcode;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_rs3, flush,
    input  alu_ready, div_ready, fpu_ready, wb_valid, wb_rd,
    output in_ready, iss_opcode, iss_rd, iss_rs1, iss_rs2, iss_rs3,
    output alu_valid, div_valid, fpu_valid, fpu_long,
    output illegal_valid, illegal_opcode, stall_cnt
  );

  modport slave (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_rs3, flush,
    output alu_ready, div_ready, fpu_ready, wb_valid, wb_rd,
    input  in_ready, iss_opcode, iss_rd, iss_rs1, iss_rs2, iss_rs3,
    input  alu_valid, div_valid, fpu_valid, fpu_long,
    input  illegal_valid, illegal_opcode, stall_cnt
  );
endinterface

// File: rtl/gpu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// gpu_issue_scheduler
// One-entry issue buffer between warp decode and the execution units.
// The buffered opcode is classified at accept time (ALU / DIV / FPU /
// illegal), a register scoreboard blocks RAW/WAW hazards, and illegal
// opcodes are consumed and reported.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - gpu_issue_scheduler_if.master (decode handshake, issue bus,
//          unit handshakes, writeback lanes, status outputs)
// ---------------------------------------------------------------------------
module gpu_issue_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  gpu_issue_scheduler_if.master bus
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_DIV = 2'd1,
    CLS_FPU = 2'd2,
    CLS_ILL = 2'd3
  } cls_t;

  function automatic logic in_rng(input logic [7:0] op, input logic [7:0] lo,
                                  input logic [7:0] hi);
    return (op >= lo) && (op <= hi);
  endfunction

  // DIV is tested first because 0x04 sits inside the 0x01-0x06 ALU run.
  function automatic cls_t classify(input logic [7:0] op);
    cls_t cls;
    if (op == 8'h04) begin
      cls = CLS_DIV;
    end else if (in_rng(op, 8'hA0, 8'hAD) || in_rng(op, 8'hB0, 8'hB5)) begin
      cls = CLS_FPU;
    end else if (in_rng(op, 8'h01, 8'h06) || in_rng(op, 8'h10, 8'h12) ||
                 in_rng(op, 8'h20, 8'h24) || in_rng(op, 8'h30, 8'h34) ||
                 in_rng(op, 8'h40, 8'h49) || in_rng(op, 8'h60, 8'h63) ||
                 in_rng(op, 8'h70, 8'h74) || in_rng(op, 8'h80, 8'h81) ||
                 in_rng(op, 8'h90, 8'h92)) begin
      cls = CLS_ALU;
    end else begin
      cls = CLS_ILL;
    end
    return cls;
  endfunction

  function automatic logic rs1_only(input logic [7:0] op);
    return in_rng(op, 8'h05, 8'h06) || in_rng(op, 8'h10, 8'h12) ||
           (op == 8'h23) || in_rng(op, 8'h70, 8'h74) ||
           in_rng(op, 8'hA4, 8'hA8) || in_rng(op, 8'hAC, 8'hAD);
  endfunction

  function automatic logic is_long(input logic [7:0] op);
    return (op == 8'hA3) || in_rng(op, 8'hA6, 8'hA8);
  endfunction

  // Buffer state and decoded attributes
  state_t              state_r;
  cls_t                cls_r;
  logic                long_r;
  logic                use_rs2_r;
  logic                use_rs3_r;
  logic [7:0]          opcode_r;
  logic [REG_W-1:0]    rd_r;
  logic [REG_W-1:0]    rs1_r;
  logic [REG_W-1:0]    rs2_r;
  logic [REG_W-1:0]    rs3_r;

  // Scoreboard and status
  logic [NUM_REGS-1:0] busy_r;
  logic                illegal_valid_r;
  logic [7:0]          illegal_opcode_r;
  logic [CNT_W-1:0]    stall_cnt_r;

  // Combinational control
  logic                full_s;
  logic                hazard_s;
  logic                issuable_s;
  logic                alu_valid_s;
  logic                div_valid_s;
  logic                fpu_valid_s;
  logic                fire_s;
  logic                illegal_consume_s;
  logic                leaving_s;
  logic                in_ready_s;
  logic                accept_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] busy_next_s;

  // Hazard detection, unit valids and the buffer leave/accept decision
  always_comb begin
    full_s            = (state_r == ST_FULL);
    hazard_s          = busy_r[rs1_r] | (use_rs2_r & busy_r[rs2_r]) |
                        (use_rs3_r & busy_r[rs3_r]) | busy_r[rd_r];
    issuable_s        = full_s & ~hazard_s & ~bus.flush;
    alu_valid_s       = issuable_s & (cls_r == CLS_ALU);
    div_valid_s       = issuable_s & (cls_r == CLS_DIV);
    fpu_valid_s       = issuable_s & (cls_r == CLS_FPU);
    fire_s            = (alu_valid_s & bus.alu_ready) |
                        (div_valid_s & bus.div_ready) |
                        (fpu_valid_s & bus.fpu_ready);
    illegal_consume_s = full_s & (cls_r == CLS_ILL) & ~bus.flush;
    leaving_s         = bus.flush | fire_s | illegal_consume_s;
    in_ready_s        = ~full_s | leaving_s;
    accept_s          = bus.in_valid & in_ready_s;
  end

  // Next scoreboard: writeback lanes clear, then an issue sets (set wins)
  always_comb begin
    clr_mask_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < 3; i++) begin
      clr_mask_s[bus.wb_rd[i*REG_W +: REG_W]] =
        clr_mask_s[bus.wb_rd[i*REG_W +: REG_W]] | bus.wb_valid[i];
    end
    set_mask_s        = {NUM_REGS{1'b0}};
    set_mask_s[rd_r]  = fire_s & (rd_r != {REG_W{1'b0}});
    busy_next_s       = (busy_r & ~clr_mask_s) | set_mask_s;
    busy_next_s[0]    = 1'b0;
  end

  // Buffer FSM: load on accept, drain on issue / illegal consume / flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_EMPTY;
      cls_r     <= CLS_ILL;
      long_r    <= 1'b0;
      use_rs2_r <= 1'b0;
      use_rs3_r <= 1'b0;
      opcode_r  <= 8'h00;
      rd_r      <= {REG_W{1'b0}};
      rs1_r     <= {REG_W{1'b0}};
      rs2_r     <= {REG_W{1'b0}};
      rs3_r     <= {REG_W{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY, ST_FULL: begin
          if (accept_s) begin
            state_r   <= ST_FULL;
            cls_r     <= classify(bus.in_opcode);
            long_r    <= is_long(bus.in_opcode);
            use_rs2_r <= ~rs1_only(bus.in_opcode);
            use_rs3_r <= (bus.in_opcode == 8'hA9);
            opcode_r  <= bus.in_opcode;
            rd_r      <= bus.in_rd;
            rs1_r     <= bus.in_rs1;
            rs2_r     <= bus.in_rs2;
            rs3_r     <= bus.in_rs3;
          end else if (leaving_s) begin
            state_r <= ST_EMPTY;
          end
        end
        default: state_r <= ST_EMPTY;
      endcase
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Illegal-opcode report and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_valid_r  <= 1'b0;
      illegal_opcode_r <= 8'h00;
      stall_cnt_r      <= {CNT_W{1'b0}};
    end else begin
      illegal_valid_r <= illegal_consume_s;
      if (illegal_consume_s) begin
        illegal_opcode_r <= opcode_r;
      end
      if (full_s && !leaving_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.iss_opcode     = opcode_r;
  assign bus.iss_rd         = rd_r;
  assign bus.iss_rs1        = rs1_r;
  assign bus.iss_rs2        = rs2_r;
  assign bus.iss_rs3        = rs3_r;
  assign bus.alu_valid      = alu_valid_s;
  assign bus.div_valid      = div_valid_s;
  assign bus.fpu_valid      = fpu_valid_s;
  assign bus.fpu_long       = fpu_valid_s & long_r;
  assign bus.illegal_valid  = illegal_valid_r;
  assign bus.illegal_opcode = illegal_opcode_r;
  assign bus.stall_cnt      = stall_cnt_r;

endmodule

// File: tb/tb_gpu_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gpu_issue_scheduler
// Every cycle is compared against a behavioural reference model (opcode
// sets, a busy array and a one-slot buffer). On top of that: an opcode
// classification table, hand-written multi-cycle sequences, and a
// randomized run. CNT_W is reduced so stall saturation is reachable.
// ---------------------------------------------------------------------------
module tb_gpu_issue_scheduler;
  localparam int REG_W = 5;
  localparam int CNT_W = 10;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  gpu_issue_scheduler_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus();
  gpu_issue_scheduler #(.NUM_REGS(32), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int alu_hs  = 0;

  // Reference model state
  bit         m_full;
  logic [7:0] m_op;
  logic [4:0] m_rd, m_rs1, m_rs2, m_rs3;
  bit         busy [32];
  bit         m_ill_v;
  logic [7:0] m_ill_op;
  int         m_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = ALU, 1 = DIV, 2 = FPU, 3 = illegal (same order as wb_valid lanes)
  function automatic int unit_of(input logic [7:0] op);
    if (op == 8'h04) return 1;
    if (op inside {[8'hA0:8'hAD], [8'hB0:8'hB5]}) return 2;
    if (op inside {[8'h01:8'h03], 8'h05, 8'h06, [8'h10:8'h12], [8'h20:8'h24],
                   [8'h30:8'h34], [8'h40:8'h49], [8'h60:8'h63], [8'h70:8'h74],
                   8'h80, 8'h81, [8'h90:8'h92]}) return 0;
    return 3;
  endfunction

  function automatic int srcs_of(input logic [7:0] op);
    if (op == 8'hA9) return 3;
    if (op inside {8'h05, 8'h06, [8'h10:8'h12], 8'h23, [8'h70:8'h74],
                   [8'hA4:8'hA8], 8'hAC, 8'hAD}) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_full = 0; m_op = 8'h00; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_rs3 = 0;
    foreach (busy[i]) busy[i] = 0;
    m_ill_v = 0; m_ill_op = 8'h00; m_stall = 0;
  endtask

  // One clock: compare DUT with the model mid-cycle, advance the model,
  // then return just after the rising edge so the caller can drive inputs.
  task automatic cycle(output bit acc);
    int unit; int ns; bit haz; bit flsh; bit fire; bit ill; bit leave; bit rdy_exp;
    logic [2:0] ev; logic [2:0] rdy;
    @(negedge clk);
    flsh = bus.flush;
    unit = unit_of(m_op);
    ns   = srcs_of(m_op);
    haz  = busy[m_rs1] || (ns >= 2 && busy[m_rs2]) || (ns == 3 && busy[m_rs3]) || busy[m_rd];
    ev   = 3'b000;
    if (m_full && unit < 3 && !haz && !flsh) ev[unit] = 1'b1;
    rdy     = {bus.fpu_ready, bus.div_ready, bus.alu_ready};
    fire    = |(ev & rdy);
    ill     = m_full && unit == 3 && !flsh;
    leave   = flsh || fire || ill;
    rdy_exp = !m_full || leave;
    chk("in_ready", bus.in_ready, rdy_exp);
    chk("unit_valid", {bus.fpu_valid, bus.div_valid, bus.alu_valid}, ev);
    chk("fpu_long", bus.fpu_long, ev[2] && (m_op inside {8'hA3, 8'hA6, 8'hA7, 8'hA8}));
    chk("iss_bus", {bus.iss_opcode, bus.iss_rd, bus.iss_rs1, bus.iss_rs2, bus.iss_rs3},
        {m_op, m_rd, m_rs1, m_rs2, m_rs3});
    chk("illegal_valid", bus.illegal_valid, m_ill_v);
    chk("illegal_opcode", bus.illegal_opcode, m_ill_op);
    chk("stall_cnt", bus.stall_cnt, m_stall);
    if (bus.alu_valid && bus.alu_ready) alu_hs++;
    if (m_full && !leave && m_stall < STALL_MAX) m_stall++;
    m_ill_v = ill;
    if (ill) m_ill_op = m_op;
    for (int i = 0; i < 3; i++) if (bus.wb_valid[i]) busy[bus.wb_rd[i*REG_W +: REG_W]] = 0;
    if (fire && m_rd != 0) busy[m_rd] = 1;
    acc = bus.in_valid && rdy_exp;
    if (acc) begin
      m_full = 1; m_op = bus.in_opcode; m_rd = bus.in_rd;
      m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2; m_rs3 = bus.in_rs3;
    end else if (leave) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    bus.wb_valid = 3'b000;
    bus.flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic send(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rs3);
    bit acc = 0;
    int n = 0;
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_rd = rd;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rs3 = rs3;
    while (!acc && n < 64) begin
      cycle(acc);
      n++;
    end
    chk("accept_timeout", acc, 1'b1);
    bus.in_valid = 1'b0;
    #1;
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs are checked
  // while reset is still asserted and before any clock edge.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_valids", {bus.alu_valid, bus.div_valid, bus.fpu_valid, bus.fpu_long}, 4'b0000);
    chk("rst_illegal", {bus.illegal_valid, bus.illegal_opcode}, 9'h000);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_iss", {bus.iss_opcode, bus.iss_rd, bus.iss_rs1, bus.iss_rs2, bus.iss_rs3}, 0);
    chk("rst_busy", dut.busy_r, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, 255));
      1:       return 8'h04;
      2:       return 8'($urandom_range(32'hA0, 32'hB7));
      default: return 8'($urandom_range(0, 32'h95));
    endcase
  endfunction

  typedef struct {
    logic [7:0] op;
    int         unit;
    bit         lng;
  } vec_t;
  vec_t vecs [26];

  initial begin
    bit acc;
    logic [2:0] exp_oh;
    vecs[0]  = '{8'h01, 0, 1'b0}; vecs[1]  = '{8'h03, 0, 1'b0};
    vecs[2]  = '{8'h04, 1, 1'b0}; vecs[3]  = '{8'h06, 0, 1'b0};
    vecs[4]  = '{8'h07, 3, 1'b0}; vecs[5]  = '{8'h00, 3, 1'b0};
    vecs[6]  = '{8'h24, 0, 1'b0}; vecs[7]  = '{8'h25, 3, 1'b0};
    vecs[8]  = '{8'h49, 0, 1'b0}; vecs[9]  = '{8'h4A, 3, 1'b0};
    vecs[10] = '{8'h81, 0, 1'b0}; vecs[11] = '{8'h82, 3, 1'b0};
    vecs[12] = '{8'h92, 0, 1'b0}; vecs[13] = '{8'h93, 3, 1'b0};
    vecs[14] = '{8'hA0, 2, 1'b0}; vecs[15] = '{8'hA3, 2, 1'b1};
    vecs[16] = '{8'hA5, 2, 1'b0}; vecs[17] = '{8'hA7, 2, 1'b1};
    vecs[18] = '{8'hA8, 2, 1'b1}; vecs[19] = '{8'hA9, 2, 1'b0};
    vecs[20] = '{8'hAD, 2, 1'b0}; vecs[21] = '{8'hAE, 3, 1'b0};
    vecs[22] = '{8'hB5, 2, 1'b0}; vecs[23] = '{8'hB6, 3, 1'b0};
    vecs[24] = '{8'h74, 0, 1'b0}; vecs[25] = '{8'hFF, 3, 1'b0};

    bus.in_valid = 0; bus.in_opcode = 0; bus.in_rd = 0; bus.in_rs1 = 0;
    bus.in_rs2 = 0; bus.in_rs3 = 0; bus.flush = 0; bus.wb_valid = 0; bus.wb_rd = 0;
    bus.alu_ready = 1; bus.div_ready = 1; bus.fpu_ready = 1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Classification table: rd = 0 and sources = 0 so nothing ever hazards
    foreach (vecs[i]) begin
      send(vecs[i].op, 5'd0, 5'd0, 5'd0, 5'd0);
      exp_oh = (vecs[i].unit < 3) ? 3'(1 << vecs[i].unit) : 3'b000;
      chk($sformatf("tbl_valid_%02h", vecs[i].op),
          {bus.fpu_valid, bus.div_valid, bus.alu_valid}, exp_oh);
      chk($sformatf("tbl_long_%02h", vecs[i].op), bus.fpu_long, vecs[i].lng);
      cycle(acc);
      chk($sformatf("tbl_illegal_%02h", vecs[i].op), bus.illegal_valid, vecs[i].unit == 3);
    end

    // Back-to-back ALU issue
    do_reset();
    alu_hs = 0;
    send(8'h01, 5'd1, 5'd2, 5'd3, 5'd0);
    send(8'h01, 5'd4, 5'd5, 5'd6, 5'd0);
    idle(1);
    chk("b2b_handshakes", alu_hs, 2);
    chk("b2b_busy1", dut.busy_r[1], 1'b1);
    chk("b2b_busy4", dut.busy_r[4], 1'b1);
    chk("b2b_stall", bus.stall_cnt, 0);

    // RAW on an FPU result, released by an FPU writeback
    do_reset();
    send(8'hA2, 5'd7, 5'd1, 5'd2, 5'd0);
    send(8'h01, 5'd8, 5'd7, 5'd1, 5'd0);
    idle(3);
    chk("raw_alu_blocked", bus.alu_valid, 1'b0);
    chk("raw_stall", bus.stall_cnt, 3);
    bus.wb_valid = 3'b100;
    bus.wb_rd = {5'd7, 5'd0, 5'd0};
    idle(1);
    #1;
    chk("raw_alu_released", bus.alu_valid, 1'b1);
    idle(1);

    // Divider held off by div_ready
    do_reset();
    bus.div_ready = 0;
    send(8'h04, 5'd9, 5'd1, 5'd2, 5'd0);
    idle(5);
    chk("div_stall", bus.stall_cnt, 5);
    chk("div_valid_held", bus.div_valid, 1'b1);
    chk("div_in_ready", bus.in_ready, 1'b0);
    bus.div_ready = 1;
    idle(1);
    chk("div_busy9", dut.busy_r[9], 1'b1);

    // Stall counter saturation
    do_reset();
    bus.div_ready = 0;
    send(8'h04, 5'd9, 5'd1, 5'd2, 5'd0);
    idle(STALL_MAX + 6);
    chk("stall_saturate", bus.stall_cnt, STALL_MAX);
    bus.div_ready = 1;
    idle(1);

    // Illegal opcode consumed and reported
    do_reset();
    send(8'h07, 5'd3, 5'd1, 5'd2, 5'd0);
    chk("ill_no_valid", {bus.fpu_valid, bus.div_valid, bus.alu_valid}, 3'b000);
    chk("ill_leaving", bus.in_ready, 1'b1);
    idle(1);
    chk("ill_pulse", bus.illegal_valid, 1'b1);
    chk("ill_opcode", bus.illegal_opcode, 8'h07);
    send(8'h01, 5'd0, 5'd1, 5'd2, 5'd0);
    chk("ill_pulse_end", bus.illegal_valid, 1'b0);
    chk("ill_opcode_held", bus.illegal_opcode, 8'h07);
    idle(1);

    // FSQRT ignores a busy rs2; rd = 0 never becomes busy
    do_reset();
    send(8'h01, 5'd3, 5'd1, 5'd2, 5'd0);
    send(8'hA6, 5'd0, 5'd5, 5'd3, 5'd0);
    chk("fsqrt_valid", bus.fpu_valid, 1'b1);
    chk("fsqrt_long", bus.fpu_long, 1'b1);
    idle(1);
    chk("fsqrt_busy0", dut.busy_r[0], 1'b0);
    chk("fsqrt_busy3", dut.busy_r[3], 1'b1);

    // Flush while stalled, then reset while full with busy bits
    do_reset();
    send(8'h04, 5'd9, 5'd1, 5'd2, 5'd0);
    send(8'h01, 5'd10, 5'd9, 5'd0, 5'd0);
    idle(2);
    bus.flush = 1;
    idle(1);
    chk("flush_empty", bus.in_ready, 1'b1);
    chk("flush_no_valid", bus.alu_valid, 1'b0);
    chk("flush_busy9", dut.busy_r[9], 1'b1);
    send(8'h01, 5'd11, 5'd9, 5'd0, 5'd0);
    idle(1);
    do_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_opcode = rand_op();
      bus.in_rd     = 5'($urandom_range(0, 7));
      bus.in_rs1    = 5'($urandom_range(0, 7));
      bus.in_rs2    = 5'($urandom_range(0, 7));
      bus.in_rs3    = 5'($urandom_range(0, 7));
      bus.alu_ready = ($urandom_range(0, 3) != 0);
      bus.div_ready = ($urandom_range(0, 3) != 0);
      bus.fpu_ready = ($urandom_range(0, 3) != 0);
      bus.wb_valid  = 3'($urandom_range(0, 7));
      bus.wb_rd     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.flush     = ($urandom_range(0, 31) == 0);
      cycle(acc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
